// File: rtl/id_ex_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// id_ex_hazard_ctrl_if : hazard-controller pipeline bus (rev 1.0)
// ============================================================================
interface id_ex_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_memread;
  logic             ex_regwr;
  logic [4:0]       ex_wreg;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: reports stage contents, consumes the controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
           ex_memread, ex_regwr, ex_wreg, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, mem_err, stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
           ex_memread, ex_regwr, ex_wreg, ex_branch_taken,
           mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, mem_err, stall_cycles, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// id_ex_hazard_ctrl : load-use stall, branch/jump flush, data-memory freeze
//                     with watchdog, stall/flush performance counters (rev 1.0)
// ============================================================================
module id_ex_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  id_ex_hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic memwait;
  logic load_use;
  logic frozen;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;

  always_comb begin
    memwait  = hz.mem_req && !hz.mem_ready;
    load_use = hz.ex_memread && hz.ex_regwr && (hz.ex_wreg != 5'd0) &&
               ((hz.id_uses_rs && (hz.id_rs == hz.ex_wreg)) ||
                (hz.id_uses_rt && (hz.id_rt == hz.ex_wreg)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Release happens in the same cycle as mem_ready or watchdog expiry.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    frozen     = 1'b0;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (memwait) begin
          frozen  = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          frozen     = 1'b1;
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b0;
    if (!reset && !frozen) begin
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      if (hz.ex_branch_taken) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        // Holding IF/ID also defers any jump in ID until the load has left EX.
        idex_flush = 1'b1;
      end else if (hz.id_jump) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (ifid_flush && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_write   = idex_write;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_write  = exmem_write;
  assign hz.mem_err      = mem_err_q;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: doc/id_ex_hazard_ctrl.md
# id_ex_hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register:
- stalls on load-use hazards;
- flushes wrong-path instructions on taken branches and jumps;
- freezes the whole pipeline while the data memory handshake is outstanding, with a watchdog.

It sits beside the ID/EX register and has two performance counters.

## Interface
- TIMEOUT, 16: maximum MEM_WAIT cycles before the watchdog fires (≥2).
- CNT_W, 16: width of the performance counters.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads rs / rt
- id_jump  in  1  the ID instruction is j/jal/jr/jalr (target resolved in ID)
- ex_memread  in  1  the EX instruction is a load (MemtoReg == 2'b01)
- ex_regwr  in  1  the EX instruction writes the register file
- ex_wreg  in  5  destination register of the EX instruction (after RegDst)
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  the MEM stage accesses data memory this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX loads a bubble (all control fields 0)
- exmem_write  out  1  EX/MEM and MEM/WB load enable
- mem_err  out  1  sticky: the watchdog expired
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write = 0
- flush_count  out  CNT_W  saturating count of cycles with ifid_flush = 1

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- The control outputs are combinational from the state and the inputs.
- memwait condition: mem_req && !mem_ready.
- load-use condition: ex_memread && ex_regwr && ex_wreg != 0 && ((id_uses_rs && id_rs == ex_wreg) || (id_uses_rt && id_rt == ex_wreg)).
- Action priority per cycle, highest first:
  1. Freeze, in MEM_WAIT, or in RUN with memwait: all write enables 0, no flush.
  2. ex_branch_taken: pc_write = 1, ifid_flush = 1, idex_flush = 1.
  3. load-use: pc_write = 0, ifid_write = 0, idex_flush = 1. Stall wins over id_jump, so a jr whose target is a pending load is not taken early.
  4. id_jump: pc_write = 1, ifid_flush = 1.
  5. Default: all write enables 1, no flush.
- When the controller is not frozen, idex_write and exmem_write are 1.
- Flush has priority over write for the same register: when flushing, the register loads a NOP/bubble.
- Transitions:
  - RUN → MEM_WAIT on memwait.
  - MEM_WAIT → RUN when mem_ready = 1. The freeze is released in that same cycle, so the outputs take the action for the current inputs.
  - MEM_WAIT → RUN when wait_cnt reaches TIMEOUT−1 without mem_ready. mem_err is set, and the freeze is released that cycle (the access is abandoned).
- wait_cnt (16 bit):
  - cleared in RUN;
  - incremented each MEM_WAIT cycle without mem_ready.
- Counters increment at the clock edge and saturate at all-ones; they never wrap.
- mem_err clears only on reset.

## Timing
- Reset values while reset = 1, and after release until inputs change:
  - state RUN, mem_err 0, stall_cycles 0, flush_count 0, wait_cnt 0;
  - pc_write, ifid_write, idex_write and exmem_write are 0 during reset;
  - ifid_flush and idex_flush are 0 during reset;
  - after release, the outputs follow the RUN rules.
- Load-use stall lasts exactly 1 cycle: on the next edge the load leaves EX, so the condition clears.
- Branch flush lasts 1 cycle and removes 2 wrong-path instructions.
- Jump flush lasts 1 cycle and removes 1 instruction.
- Freeze holds every pipeline register, including ex_branch_taken, stable. Any branch, jump or hazard is acted on in the first unfrozen cycle.
- Reset asserted mid-MEM_WAIT: the FSM returns to RUN immediately and wait_cnt is cleared.
- Freeze latency from mem_req && !mem_ready: 0 cycles (combinational).

## Test plan
- lw $2 in EX with ex_wreg = 2, and an ID instruction using rs = 2 → one cycle of pc_write = 0, ifid_write = 0, idex_flush = 1, then normal flow; stall_cycles = 1.
- Same case with ex_wreg = 0, or with ex_memread = 0 → no stall.
- ex_branch_taken = 1 together with load-use and id_jump → pc_write = 1, ifid_flush = 1, idex_flush = 1; flush_count increments by 1.
- Load-use plus id_jump in the same cycle → stall only, ifid_flush = 0; the next cycle performs the jump flush.
- mem_req = 1 with mem_ready low for 3 cycles, then high → all enables 0 for 3 cycles, released in the 4th cycle; stall_cycles += 3; mem_err = 0.
- mem_ready never rises with TIMEOUT = 4 → freeze for 4 cycles, mem_err = 1 and stays 1; reset clears it. Also assert reset mid-wait and check that all outputs and the counters return to their reset values.
